// File: rtl/iic_slave_mem.sv
// I2C target emulating a small 24Cxx-style EEPROM: oversampled bus decode,
// device-address ACK, 1/2-byte word address, auto-incrementing byte memory.
module iic_slave_mem #(
    parameter logic [6:0] DEVICE    = 7'b1010_000,
    parameter int         ADDRWIDTH = 16,
    parameter int         MEMAW     = 6
) (
    input  logic             I_clk,
    input  logic             I_rstn,
    input  logic             I_scl,
    input  logic             I_sda,
    output logic             O_sda,
    output logic             O_busy,
    output logic             O_wr_pulse,
    output logic [MEMAW-1:0] O_wr_addr,
    output logic [7:0]       O_wr_data
);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, ADDR_HI, ADDR_LO, ACK_ADDR,
        WRDATA, ACK_WR, RDDATA, RD_ACKCHK, IGNORE
    } state_t;

    // Synchronizers reset to the idle-bus level so release of reset
    // cannot fabricate a START or STOP.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            scl_sync <= {scl_sync[0], I_scl};
            sda_sync <= {sda_sync[0], I_sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    logic scl_s, sda_s;
    logic start_ev, stop_ev, scl_rise, scl_fall;

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    state_t           state, state_n;
    logic [6:0]       shreg, shreg_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic             phase, phase_n;
    logic             rw, rw_n;
    logic             addr_last, addr_last_n;
    logic [7:0]       addr_hi, addr_hi_n;
    logic [MEMAW-1:0] ptr, ptr_n;
    logic             sda_n, busy_n, wr_pulse_n;
    logic [MEMAW-1:0] wr_addr_n;
    logic [7:0]       wr_data_n;
    logic             mem_we;

    logic [7:0] mem [2**MEMAW];
    logic [7:0] mem_rdata;
    logic [7:0] byte_in;
    logic       last_bit;

    assign mem_rdata = mem[ptr];
    assign byte_in   = {shreg, sda_s};
    assign last_bit  = (bitcnt == 4'd7);

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped one would infer a latch.
        state_n     = state;
        shreg_n     = shreg;
        bitcnt_n    = bitcnt;
        phase_n     = phase;
        rw_n        = rw;
        addr_last_n = addr_last;
        addr_hi_n   = addr_hi;
        ptr_n       = ptr;
        sda_n       = O_sda;
        busy_n      = O_busy;
        wr_pulse_n  = 1'b0;
        wr_addr_n   = O_wr_addr;
        wr_data_n   = O_wr_data;
        mem_we      = 1'b0;

        if (stop_ev) begin
            state_n  = IDLE;
            sda_n    = 1'b1;
            busy_n   = 1'b0;
            bitcnt_n = 4'd0;
        end else if (start_ev) begin
            state_n  = DEVADDR;
            sda_n    = 1'b1;
            busy_n   = 1'b0;
            bitcnt_n = 4'd0;
        end else begin
            unique case (state)
                DEVADDR: if (scl_rise) begin
                    shreg_n  = byte_in[6:0];
                    bitcnt_n = bitcnt + 4'd1;
                    if (last_bit) begin
                        rw_n    = sda_s;
                        phase_n = 1'b0;
                        state_n = (byte_in[7:1] == DEVICE) ? ACK_DEV : IGNORE;
                    end
                end
                // ACK states: first SCL fall pulls SDA low, second releases it.
                ACK_DEV: if (scl_fall) begin
                    if (!phase) begin
                        sda_n   = 1'b0;
                        busy_n  = 1'b1;
                        phase_n = 1'b1;
                    end else begin
                        phase_n  = 1'b0;
                        bitcnt_n = 4'd0;
                        if (rw) begin
                            sda_n   = mem_rdata[7];
                            shreg_n = mem_rdata[6:0];
                            state_n = RDDATA;
                        end else begin
                            sda_n   = 1'b1;
                            state_n = (ADDRWIDTH == 16) ? ADDR_HI : ADDR_LO;
                        end
                    end
                end
                ADDR_HI: if (scl_rise) begin
                    shreg_n  = byte_in[6:0];
                    bitcnt_n = bitcnt + 4'd1;
                    if (last_bit) begin
                        addr_hi_n   = byte_in;
                        addr_last_n = 1'b0;
                        phase_n     = 1'b0;
                        state_n     = ACK_ADDR;
                    end
                end
                ADDR_LO: if (scl_rise) begin
                    shreg_n  = byte_in[6:0];
                    bitcnt_n = bitcnt + 4'd1;
                    if (last_bit) begin
                        ptr_n = (ADDRWIDTH == 16) ? MEMAW'({addr_hi, byte_in})
                                                  : MEMAW'({8'h00, byte_in});
                        addr_last_n = 1'b1;
                        phase_n     = 1'b0;
                        state_n     = ACK_ADDR;
                    end
                end
                ACK_ADDR, ACK_WR: if (scl_fall) begin
                    if (!phase) begin
                        sda_n   = 1'b0;
                        phase_n = 1'b1;
                    end else begin
                        sda_n    = 1'b1;
                        phase_n  = 1'b0;
                        bitcnt_n = 4'd0;
                        state_n  = (state == ACK_WR || addr_last) ? WRDATA : ADDR_LO;
                    end
                end
                WRDATA: if (scl_rise) begin
                    shreg_n  = byte_in[6:0];
                    bitcnt_n = bitcnt + 4'd1;
                    if (last_bit) begin
                        mem_we     = 1'b1;
                        wr_pulse_n = 1'b1;
                        wr_addr_n  = ptr;
                        wr_data_n  = byte_in;
                        ptr_n      = ptr + 1'b1;
                        phase_n    = 1'b0;
                        state_n    = ACK_WR;
                    end
                end
                RDDATA: begin
                    if (scl_rise) begin
                        bitcnt_n = bitcnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            sda_n    = 1'b1;
                            bitcnt_n = 4'd0;
                            phase_n  = 1'b0;
                            state_n  = RD_ACKCHK;
                        end else begin
                            sda_n   = shreg[6];
                            shreg_n = {shreg[5:0], 1'b0};
                        end
                    end
                end
                // phase marks an ACK seen; the next byte is loaded on the fall.
                RD_ACKCHK: begin
                    if (scl_rise && !phase) begin
                        if (!sda_s) begin
                            ptr_n   = ptr + 1'b1;
                            phase_n = 1'b1;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && phase) begin
                        sda_n    = mem_rdata[7];
                        shreg_n  = mem_rdata[6:0];
                        bitcnt_n = 4'd0;
                        phase_n  = 1'b0;
                        state_n  = RDDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            phase      <= 1'b0;
            rw         <= 1'b0;
            addr_last  <= 1'b0;
            addr_hi    <= '0;
            ptr        <= '0;
            O_sda      <= 1'b1;
            O_busy     <= 1'b0;
            O_wr_pulse <= 1'b0;
            O_wr_addr  <= '0;
            O_wr_data  <= '0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            phase      <= phase_n;
            rw         <= rw_n;
            addr_last  <= addr_last_n;
            addr_hi    <= addr_hi_n;
            ptr        <= ptr_n;
            O_sda      <= sda_n;
            O_busy     <= busy_n;
            O_wr_pulse <= wr_pulse_n;
            O_wr_addr  <= wr_addr_n;
            O_wr_data  <= wr_data_n;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM/flops
    // without a reset tree; contents survive I_rstn.
    always_ff @(posedge I_clk) begin
        if (mem_we) mem[ptr] <= byte_in;
    end

endmodule
